// File: rtl/ps2_commandes_pkg.sv
// rtl/ps2_commandes_pkg.sv - scancodes, key indices and lookup shared by the PS/2 command decoder
package ps2_commandes_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_Z        = 8'h1A;
  localparam logic [7:0] SC_S        = 8'h1B;
  localparam logic [7:0] SC_Q        = 8'h15;
  localparam logic [7:0] SC_D        = 8'h23;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;

  localparam int NUM_KEYS = 10;

  typedef enum logic [3:0] {
    K1_UP, K1_DOWN, K1_LEFT, K1_RIGHT, K1_BOMB,
    K2_UP, K2_DOWN, K2_LEFT, K2_RIGHT, K2_BOMB
  } key_idx_e;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // One-hot key hit for a code; arrow/enter codes only count behind an E0 prefix
  function automatic key_vec_t key_lookup(input logic ext, input logic [7:0] code);
    key_vec_t hit;
    hit = '0;
    if (!ext) begin
      case (code)
        SC_Z:     hit[K1_UP]    = 1'b1;
        SC_S:     hit[K1_DOWN]  = 1'b1;
        SC_Q:     hit[K1_LEFT]  = 1'b1;
        SC_D:     hit[K1_RIGHT] = 1'b1;
        SC_SPACE: hit[K1_BOMB]  = 1'b1;
        default:  hit = '0;
      endcase
    end else begin
      case (code)
        SC_UP:       hit[K2_UP]    = 1'b1;
        SC_DOWN:     hit[K2_DOWN]  = 1'b1;
        SC_LEFT:     hit[K2_LEFT]  = 1'b1;
        SC_RIGHT:    hit[K2_RIGHT] = 1'b1;
        SC_KP_ENTER: hit[K2_BOMB]  = 1'b1;
        default:     hit = '0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_commandes_if.sv
// rtl/ps2_commandes_if.sv - PS/2 line inputs plus key flags and byte strobes of the decoder
interface ps2_commandes_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic       j1_up;
  logic       j1_down;
  logic       j1_left;
  logic       j1_right;
  logic       j1_bomb;
  logic       j2_up;
  logic       j2_down;
  logic       j2_left;
  logic       j2_right;
  logic       j2_bomb;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  j1_up, j1_down, j1_left, j1_right, j1_bomb,
    input  j2_up, j2_down, j2_left, j2_right, j2_bomb,
    input  byte_valid, byte_data, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output j1_up, j1_down, j1_left, j1_right, j1_bomb,
    output j2_up, j2_down, j2_left, j2_right, j2_bomb,
    output byte_valid, byte_data, frame_err
  );

endinterface

// File: rtl/ps2_commandes_rx.sv
// rtl/ps2_commandes_rx.sv - PS/2 receiver: synchroniser, clock glitch filter, frame FSM, timeout
module ps2_commandes_rx
  import ps2_commandes_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_clk_q, filt_clk_d;
  logic          filt_prev_q, filt_prev_d;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          frame_err_q, frame_err_d;

  logic fall;
  logic edge_any;
  logic din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_cnt_q   <= '0;
      filt_clk_q   <= 1'b1;
      filt_prev_q  <= 1'b1;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      idle_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      filt_cnt_q   <= filt_cnt_d;
      filt_clk_q   <= filt_clk_d;
      filt_prev_q  <= filt_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // The filtered clock only flips after FILTER consecutive samples disagree with it
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_clk_d  = filt_clk_q;
    filt_prev_d = filt_clk_q;
    filt_cnt_d  = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER - 1)) begin
        filt_clk_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall     = filt_prev_q & ~filt_clk_q;
  assign edge_any = filt_prev_q ^ filt_clk_q;
  assign din      = data_sync_q[1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;
    idle_cnt_d   = (edge_any || state_q == RX_IDLE) ? '0 : idle_cnt_q + 1'b1;

    case (state_q)
      RX_IDLE: begin
        if (fall && !din) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
          parity_d  = 1'b0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d   = {din, shift_q[7:1]};
          parity_d  = parity_q ^ din;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall) begin
          parity_d = parity_q ^ din;
          state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          // parity_q holds the XOR of data and parity bits: 1 means odd, i.e. good
          if (parity_q && din) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (state_q != RX_IDLE && !edge_any && idle_cnt_q == TW'(TIMEOUT - 1)) begin
      state_d     = RX_IDLE;
      frame_err_d = 1'b1;
      idle_cnt_d  = '0;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_commandes.sv
// rtl/ps2_commandes.sv - PS/2 set-2 scancodes to held-key level flags for two players
module ps2_commandes
  import ps2_commandes_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_commandes_if.slave bus
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;

  ps2_commandes_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .rst        (reset),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_err)
  );

  logic     ext_q, ext_d;
  logic     brk_q, brk_d;
  key_vec_t keys_q, keys_d;
  key_vec_t hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      keys_q <= keys_d;
    end
  end

  // A broken frame must not leave a dangling prefix to corrupt the next key
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    hit    = key_lookup(ext_q, rx_data);
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_data == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        keys_d = brk_q ? (keys_q & ~hit) : (keys_q | hit);
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
  end

  assign bus.j1_up      = keys_q[K1_UP];
  assign bus.j1_down    = keys_q[K1_DOWN];
  assign bus.j1_left    = keys_q[K1_LEFT];
  assign bus.j1_right   = keys_q[K1_RIGHT];
  assign bus.j1_bomb    = keys_q[K1_BOMB];
  assign bus.j2_up      = keys_q[K2_UP];
  assign bus.j2_down    = keys_q[K2_DOWN];
  assign bus.j2_left    = keys_q[K2_LEFT];
  assign bus.j2_right   = keys_q[K2_RIGHT];
  assign bus.j2_bomb    = keys_q[K2_BOMB];
  assign bus.byte_valid = rx_valid;
  assign bus.byte_data  = rx_data;
  assign bus.frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_commandes.sv
// tb/tb_ps2_commandes.sv - scoreboard bench for the PS/2 command decoder
module tb_ps2_commandes;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_commandes_if bus ();

  ps2_commandes #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       is_err;
    bit [7:0] data;
    bit [9:0] flags;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  bit       m_ext;
  bit       m_brk;
  bit [9:0] m_flags;

  // {ext, code} per flag, in order j1 up/down/left/right/bomb then j2
  bit [8:0] key_tab [10] = '{9'h01A, 9'h01B, 9'h015, 9'h023, 9'h029,
                             9'h175, 9'h172, 9'h16B, 9'h174, 9'h15A};
  bit [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1A, 8'h1B, 8'h15, 8'h23,
                          8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};

  function automatic bit [9:0] dut_flags();
    return {bus.j2_bomb, bus.j2_right, bus.j2_left, bus.j2_down, bus.j2_up,
            bus.j1_bomb, bus.j1_right, bus.j1_left, bus.j1_down, bus.j1_up};
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  task automatic model_byte(input bit [7:0] b);
    ev_t e;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      for (int i = 0; i < 10; i++)
        if (key_tab[i] == {m_ext, b}) m_flags[i] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    e.is_err = 1'b0; e.data = b; e.flags = m_flags;
    exp_q.push_back(e);
  endtask

  task automatic model_err();
    ev_t e;
    m_ext = 1'b0;
    m_brk = 1'b0;
    e.is_err = 1'b1; e.data = 8'h00; e.flags = m_flags;
    exp_q.push_back(e);
  endtask

  task automatic drive_bits(input bit [10:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (HALF / 2) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (FILTER - 2) @(posedge clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF - HALF / 2 - (FILTER - 2)) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 good with clock glitch
  task automatic frame(input bit [7:0] b, input int kind);
    bit [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = ~(^b) ^ (kind == 1);
    bits[10]  = (kind != 2);
    if (kind == 1 || kind == 2) model_err();
    else model_byte(b);
    drive_bits(bits, 11, (kind == 3) ? int'($urandom_range(0, 10)) : -1);
  endtask

  initial begin : monitor
    ev_t e;
    int cd;
    bit [9:0] exp_f;
    cd = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) check("flags_after_event", int'(dut_flags()), int'(exp_f));
        end
        if (bus.byte_valid || bus.frame_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output valid=%0b err=%0b data=%0h exp=none",
                     bus.byte_valid, bus.frame_err, bus.byte_data);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_err", int'(bus.frame_err), int'(e.is_err));
            check("event_kind_valid", int'(bus.byte_valid), int'(!e.is_err));
            if (!e.is_err) check("byte_data", int'(bus.byte_data), int'(e.data));
            exp_f = e.flags;
            cd = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(900000 * 10);
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; m_flags = '0;
    repeat (5) @(negedge clk);
    check("reset_flags", int'(dut_flags()), 0);
    check("reset_byte_valid", int'(bus.byte_valid), 0);
    check("reset_byte_data", int'(bus.byte_data), 0);
    check("reset_frame_err", int'(bus.frame_err), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    frame(8'h1A, 0); frame(8'hF0, 0); frame(8'h1A, 0);
    frame(8'hE0, 0); frame(8'h75, 0);
    frame(8'hE0, 0); frame(8'hF0, 0); frame(8'h75, 0);
    frame(8'h75, 0);
    frame(8'h1B, 1);
    frame(8'h29, 2);
    frame(8'hE0, 0); frame(8'h74, 1); frame(8'h74, 0);

    model_err();
    drive_bits(11'b000_0010_0110, 5, -1);
    repeat (TIMEOUT + 100) @(posedge clk);
    frame(8'h23, 0);

    frame(8'h15, 3);
    frame(8'h1A, 0); frame(8'h23, 0); frame(8'hE0, 0); frame(8'h5A, 0);
    @(negedge clk);
    check("three_keys_held", int'(dut_flags()), int'(m_flags));

    drive_bits(11'b000_0011_0100, 4, -1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_midframe_flags", int'(dut_flags()), 0);
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_flags = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    frame(8'h1A, 0);

    for (int n = 0; n < 40; n++) begin
      bit [7:0] b;
      int r;
      int kind;
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                       : pool[$urandom_range(0, 11)];
      r = int'($urandom_range(0, 19));
      kind = (r < 2) ? 1 : (r < 3) ? 2 : (r < 5) ? 3 : 0;
      frame(b, kind);
    end

    repeat (50) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
